// File: rtl/da_serializer_pkg.sv
// Shared types and width helpers for the PISO serializer.
// Phase counter spans 2*HALF clocks; bit counter spans WIDTH bits.
package da_serializer_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    function automatic int phase_w(input int half);
        return $clog2(2 * half);
    endfunction

    function automatic int bit_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-side handshake and serial-side pins of the serializer.
// master = word producer, slave = serializer.
interface piso_serializer_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_CHAN = 2
);
    logic [NUM_CHAN*WIDTH-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic                      sclk;
    logic [NUM_CHAN-1:0]       sdata;
    logic                      frame;
    logic                      busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, sclk, sdata, frame, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, sclk, sdata, frame, busy
    );
endinterface

// File: rtl/ser_clk_gen.sv
// Serial clock generator: phase counter, registered sclk,
// launch strobe (shifter update edge) and wrap strobe (bit advance).
module ser_clk_gen
    import da_serializer_pkg::*;
#(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic sclk,
    output logic launch,
    output logic wrap
);
    localparam int            PW   = phase_w(HALF);
    localparam logic [PW-1:0] LAST = PW'(2 * HALF - 1);
    localparam logic [PW-1:0] MID  = PW'(HALF);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_d;

    always_comb begin
        phase_d = phase;
        if (clr)
            phase_d = '0;
        else if (en)
            phase_d = (phase == LAST) ? '0 : phase + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            sclk  <= 1'b0;
        end else begin
            phase <= phase_d;
            sclk  <= (phase_d >= MID);
        end
    end

    // wrap must not depend on clr: the load decision is built from it
    assign wrap   = en && (phase == LAST);
    assign launch = clr || wrap;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with one-word holding buffer,
// self-generated sclk and gapless back-to-back framing.
module piso_serializer
    import da_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_CHAN  = 2,
    parameter int HALF      = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    piso_serializer_if.slave  bus
);
    localparam int            BW       = bit_w(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t state;
    state_t state_d;

    logic                      hold_valid;
    logic                      hold_valid_d;
    logic [NUM_CHAN*WIDTH-1:0] hold_data;
    logic [BW-1:0]             bit_cnt;
    logic [NUM_CHAN-1:0]       head;

    logic load;
    logic accept;
    logic word_end;
    logic sclk;
    logic launch;
    logic wrap;
    logic in_ready;
    logic frame;
    logic busy;

    assign accept   = bus.in_valid && in_ready;
    assign word_end = wrap && (bit_cnt == LAST_BIT);

    ser_clk_gen #(
        .HALF (HALF)
    ) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (state == SHIFT),
        .clr    (load),
        .sclk   (sclk),
        .launch (launch),
        .wrap   (wrap)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d      = state;
        load         = 1'b0;
        hold_valid_d = hold_valid;
        unique case (state)
            IDLE: begin
                if (hold_valid) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (word_end) begin
                    if (hold_valid)
                        load = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load)
            hold_valid_d = 1'b0;
        if (accept)
            hold_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            in_ready   <= 1'b0;
            frame      <= 1'b0;
            busy       <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            hold_valid <= hold_valid_d;
            in_ready   <= !hold_valid_d;
            frame      <= (state_d == SHIFT);
            busy       <= (state_d == SHIFT) || hold_valid_d;
            if (load)
                bit_cnt <= '0;
            else if (wrap)
                bit_cnt <= bit_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            hold_data <= bus.in_data;
    end

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_lane
        logic [WIDTH-1:0] sh;

        // cleared at word end so sdata idles low without output gating
        always_ff @(posedge clk) begin
            if (reset)
                sh <= '0;
            else if (launch) begin
                if (load)
                    sh <= hold_data[c*WIDTH +: WIDTH];
                else if (word_end)
                    sh <= '0;
                else if (MSB_FIRST != 0)
                    sh <= {sh[WIDTH-2:0], 1'b0};
                else
                    sh <= {1'b0, sh[WIDTH-1:1]};
            end
        end

        if (MSB_FIRST != 0) begin : g_msb
            assign head[c] = sh[WIDTH-1];
        end else begin : g_lsb
            assign head[c] = sh[0];
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.sclk     = sclk;
    assign bus.sdata    = head;
    assign bus.frame    = frame;
    assign bus.busy     = busy;

endmodule
